// File: rtl/btn_conditioner.sv
// btn_conditioner: front-end conditioning for the clock's push buttons.
//   Each channel goes through a two-flop synchroniser and a debounce counter.
//   Each accepted edge of the debounced level gives one registered press or
//   release pulse.
//   Optional macro BTN_AUTO_REPEAT_EN: the channels selected in REPEAT_MASK
//   emit a repeat press pulse after REPEAT_DELAY held cycles, and then one
//   every REPEAT_PERIOD cycles until the debounced release.
// Ports:
//   sys_clk      system clock
//   rst          asynchronous, active-high reset
//   btn_raw      raw button levels, 1 = pressed (asynchronous)
//   btn_level    debounced level
//   btn_pulse    one-cycle press pulse (also repeat pulses when enabled)
//   btn_release  one-cycle release pulse
//   any_pulse    OR of btn_pulse, aligned with it

module btn_conditioner_ch #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000,
  parameter bit REPEAT_ON       = 1'b0
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse,
  output logic rel,
  output logic pulse_next
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;

  state_t        state, state_nx;
  logic          sync1, sync2;
  logic [CW-1:0] cnt, cnt_nx;
  logic          rel_nx, mismatch, accept, press_accept, rpt_fire;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // The counter holds the number of consecutive edges on which the
  // synchronised input disagreed with the debounced level. It provides the
  // press-wait and release-wait sub-phases of IDLE and HELD.
  assign mismatch     = sync2 != (state == HELD);
  assign accept       = mismatch && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign press_accept = accept && (state == IDLE);

`ifdef BTN_AUTO_REPEAT_EN
  if (REPEAT_ON) begin : g_rpt
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    logic [RW-1:0] rcnt, rcnt_inc, rtarget;
    logic          rphase;  // 0: waiting out the first delay, 1: periodic

    assign rcnt_inc = rcnt + 1'b1;
    assign rtarget  = rphase ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY);
    // A release accepted on the same edge wins; there is no repeat on the release edge.
    assign rpt_fire = (state == HELD) && !accept && (rcnt_inc == rtarget);

    always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
        rcnt   <= '0;
        rphase <= 1'b0;
      end else if (press_accept) begin
        rcnt   <= '0;
        rphase <= 1'b0;
      end else if (rpt_fire) begin
        rcnt   <= '0;
        rphase <= 1'b1;
      end else if (state == HELD) begin
        rcnt   <= rcnt_inc;
      end
    end
  end else begin : g_no_rpt
    assign rpt_fire = 1'b0;
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    cnt_nx     = mismatch ? cnt + 1'b1 : '0;
    pulse_next = 1'b0;
    rel_nx     = 1'b0;
    case (state)
      IDLE: if (accept) begin
        state_nx   = HELD;
        cnt_nx     = '0;
        pulse_next = 1'b1;
      end
      HELD: if (accept) begin
        state_nx = IDLE;
        cnt_nx   = '0;
        rel_nx   = 1'b1;
      end else begin
        pulse_next = rpt_fire;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
      rel   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      pulse <= pulse_next;
      rel   <= rel_nx;
    end
  end

  assign level = (state == HELD);
endmodule

module btn_conditioner #(
  parameter int                  NUM_BTNS        = 4,
  parameter int                  DEBOUNCE_CYCLES = 500000,
  parameter int                  REPEAT_DELAY    = 50000000,
  parameter int                  REPEAT_PERIOD   = 20000000,
  parameter logic [NUM_BTNS-1:0] REPEAT_MASK     = 4'b0010
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_pulse,
  output logic [NUM_BTNS-1:0] btn_release,
  output logic                any_pulse
);
  logic [NUM_BTNS-1:0] pulse_next;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    btn_conditioner_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_ON      (REPEAT_MASK[i])
    ) u_ch (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .raw       (btn_raw[i]),
      .level     (btn_level[i]),
      .pulse     (btn_pulse[i]),
      .rel       (btn_release[i]),
      .pulse_next(pulse_next[i])
    );
  end

  // Registered from the same next-state terms as btn_pulse, so it lines up with it.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) any_pulse <= 1'b0;
    else     any_pulse <= |pulse_next;
  end
endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;
  localparam int NB = 4;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 4;
  localparam logic [NB-1:0] MASK = 4'b0010;

  logic          sys_clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_raw, btn_level, btn_pulse, btn_release;
  logic          any_pulse;
  logic [NB-1:0] r_raw, r_level, r_pulse, r_release;
  logic          r_any;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  btn_conditioner #(.NUM_BTNS(NB), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD),
                    .REPEAT_PERIOD(RP), .REPEAT_MASK(MASK)) dut (
    .sys_clk(sys_clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level),
    .btn_pulse(btn_pulse), .btn_release(btn_release), .any_pulse(any_pulse));

  // Second instance with the short timings used for the repeat scenario.
  btn_conditioner #(.NUM_BTNS(NB), .DEBOUNCE_CYCLES(2), .REPEAT_DELAY(10),
                    .REPEAT_PERIOD(4), .REPEAT_MASK(4'b0010)) u_rpt (
    .sys_clk(sys_clk), .rst(rst), .btn_raw(r_raw), .btn_level(r_level),
    .btn_pulse(r_pulse), .btn_release(r_release), .any_pulse(r_any));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model for dut ----------------
  // A level is accepted once the last D synchronised samples all disagree
  // with it. Repeats are scheduled from the hold age since the press.
  logic [NB-1:0][D-1:0] m_win, nx_win;
  logic [NB-1:0]        m_s1, m_s2, m_lvl, m_pul, m_rel, nx_lvl, nx_pul, nx_rel;
  logic                 m_any;
  int                   m_age [NB];
  int                   nx_age[NB];

  always_comb begin
    nx_win = m_win;
    nx_lvl = m_lvl;
    nx_pul = '0;
    nx_rel = '0;
    for (int c = 0; c < NB; c++) nx_age[c] = m_age[c];
    for (int c = 0; c < NB; c++) begin
      nx_win[c] = {m_win[c][D-2:0], m_s2[c]};
      if (!m_lvl[c] && nx_win[c] == {D{1'b1}}) begin
        nx_lvl[c] = 1'b1;
        nx_pul[c] = 1'b1;
        nx_age[c] = 0;
      end else if (m_lvl[c] && nx_win[c] == '0) begin
        nx_lvl[c] = 1'b0;
        nx_rel[c] = 1'b1;
      end else if (m_lvl[c]) begin
        nx_age[c] = m_age[c] + 1;
`ifdef BTN_AUTO_REPEAT_EN
        if (MASK[c] && nx_age[c] >= RD && ((nx_age[c] - RD) % RP) == 0) nx_pul[c] = 1'b1;
`endif
      end
    end
  end

  always @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      m_s1 <= '0; m_s2 <= '0; m_win <= '0; m_lvl <= '0;
      m_pul <= '0; m_rel <= '0; m_any <= 1'b0;
      for (int c = 0; c < NB; c++) m_age[c] <= 0;
    end else begin
      m_s1 <= btn_raw;
      m_s2 <= m_s1;
      m_win <= nx_win;
      m_lvl <= nx_lvl;
      m_pul <= nx_pul;
      m_rel <= nx_rel;
      m_any <= |nx_pul;
      for (int c = 0; c < NB; c++) m_age[c] <= nx_age[c];
    end
  end

  always @(negedge sys_clk) begin
    chk("mdl_level",   32'(btn_level),   32'(m_lvl));
    chk("mdl_pulse",   32'(btn_pulse),   32'(m_pul));
    chk("mdl_release", 32'(btn_release), 32'(m_rel));
    chk("mdl_any",     32'(any_pulse),   32'(m_any));
  end

  // ---------------- stimulus helpers ----------------
  // One step: drive raw inputs, let one active edge pass, return at the next negedge.
  task automatic cyc(input logic [NB-1:0] a, input logic [NB-1:0] b);
    btn_raw = a;
    r_raw   = b;
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_level"},   32'(btn_level),   32'h0);
    chk({name, "_pulse"},   32'(btn_pulse),   32'h0);
    chk({name, "_release"}, 32'(btn_release), 32'h0);
    chk({name, "_any"},     32'(any_pulse),   32'h0);
  endtask

  // Asynchronous reset between edges, held across n active edges.
  task automatic rst_pulse(input int n);
    #2 rst = 1'b1;
    #1 chk_zero("rst_async");
    for (int k = 0; k < n; k++) @(posedge sys_clk);
    @(negedge sys_clk);
    chk_zero("rst_held");
    #2 rst = 1'b0;
  endtask

  typedef struct packed {
    logic [NB-1:0] raw;
    logic [NB-1:0] lvl;
    logic [NB-1:0] pul;
    logic [NB-1:0] rel;
    logic          any;
  } vec_t;

  vec_t tv [32];
  logic [7:0] bounce;
  int q1[$];
  int q0[$];
  int exp1[$];
  int n_pul, n_rel;

  initial begin
    // clean press, held 25 steps: edges counted from the first sampling edge
    for (int i = 0; i < 32; i++) begin
      tv[i].raw = (i < 25) ? 4'b0001 : 4'b0000;
      tv[i].lvl = (i >= 5 && i < 30) ? 4'b0001 : 4'b0000;
      tv[i].pul = (i == 5) ? 4'b0001 : 4'b0000;
      tv[i].rel = (i == 30) ? 4'b0001 : 4'b0000;
      tv[i].any = (i == 5);
    end
    bounce = 8'b0111_0111;  // bit i = step i: 1,1,1,0,1,1,1,0

    rst = 1'b0; btn_raw = '0; r_raw = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk_zero("reset");
    chk("reset_rpt_level", 32'(r_level), 32'h0);
    #2 rst = 1'b0;

    // table-driven clean press / release
    for (int i = 0; i < 32; i++) begin
      cyc(tv[i].raw, 4'b0000);
      chk("tv_level",   32'(btn_level),   32'(tv[i].lvl));
      chk("tv_pulse",   32'(btn_pulse),   32'(tv[i].pul));
      chk("tv_release", 32'(btn_release), 32'(tv[i].rel));
      chk("tv_any",     32'(any_pulse),   32'(tv[i].any));
    end

    // bounce on bit1, then stable high
    n_pul = 0;
    for (int i = 0; i < 16; i++) begin
      cyc((i < 8) ? {2'b00, bounce[i], 1'b0} : 4'b0010, 4'b0000);
      chk("bounce_pulse", 32'(btn_pulse), (i == 13) ? 32'h2 : 32'h0);
      n_pul += int'(btn_pulse[1]);
    end
    chk("bounce_count", 32'(n_pul), 32'd1);
    n_rel = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(4'b0000, 4'b0000);
      n_rel += int'(btn_release[1]);
    end
    chk("bounce_release_count", 32'(n_rel), 32'd1);

    // simultaneous press of bits 0 and 2
    for (int i = 0; i < 8; i++) begin
      cyc(4'b0101, 4'b0000);
      chk("multi_pulse", 32'(btn_pulse), (i == 5) ? 32'h5 : 32'h0);
      chk("multi_any",   32'(any_pulse), (i == 5) ? 32'h1 : 32'h0);
    end
    for (int i = 0; i < 8; i++) cyc(4'b0000, 4'b0000);

    // reset with bit3's debounce count at 3 of 4, button kept pressed
    for (int i = 0; i < 5; i++) cyc(4'b1000, 4'b0000);
    chk("pre_rst_pulse", 32'(btn_pulse), 32'h0);
    rst_pulse(2);
    for (int i = 0; i < 8; i++) begin
      cyc(4'b1000, 4'b0000);
      chk("post_rst_pulse", 32'(btn_pulse), (i == 5) ? 32'h8 : 32'h0);
    end
    for (int i = 0; i < 8; i++) cyc(4'b0000, 4'b0000);

    // hold bits 0 and 1 of the short-timing instance for 30 steps
`ifdef BTN_AUTO_REPEAT_EN
    exp1 = '{3, 13, 17, 21, 25, 29};
`else
    exp1 = '{3};
`endif
    n_rel = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(4'b0000, (i < 30) ? 4'b0011 : 4'b0000);
      if (r_pulse[1]) q1.push_back(i);
      if (r_pulse[0]) q0.push_back(i);
      if (r_release[1]) begin
        n_rel++;
        chk("rpt_release_step", 32'(i), 32'd33);
      end
    end
    chk("rpt1_count", 32'(q1.size()), 32'(exp1.size()));
    foreach (exp1[i])
      chk("rpt1_step", (i < q1.size()) ? 32'(q1[i]) : 32'hFFFF_FFFF, 32'(exp1[i]));
    chk("rpt0_count", 32'(q0.size()), 32'd1);
    chk("rpt0_step", (q0.size() > 0) ? 32'(q0[0]) : 32'hFFFF_FFFF, 32'd3);
    chk("rpt_release_count", 32'(n_rel), 32'd1);

    // long hold of bit1 on the main instance
    n_pul = 0; n_rel = 0;
    for (int i = 0; i < 1010; i++) begin
      cyc((i < 1000) ? 4'b0010 : 4'b0000, 4'b0000);
      n_pul += int'(btn_pulse[1]);
      n_rel += int'(btn_release[1]);
    end
`ifdef BTN_AUTO_REPEAT_EN
    chk("long_hold_pulses", 32'(n_pul), 32'd249);
`else
    chk("long_hold_pulses", 32'(n_pul), 32'd1);
`endif
    chk("long_hold_releases", 32'(n_rel), 32'd1);

    // random phase: alternating bouncy and calm blocks, occasional reset
    for (int blk = 0; blk < 60; blk++) begin
      int tp;
      tp = ($urandom_range(0, 1) == 0) ? 3 : 40;
      for (int k = 0; k < 50; k++) begin
        logic [NB-1:0] nr;
        nr = btn_raw;
        for (int b = 0; b < NB; b++)
          if ($urandom_range(0, tp - 1) == 0) nr[b] = ~nr[b];
        if ($urandom_range(0, 299) == 0) rst_pulse(1);
        cyc(nr, 4'b0000);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
